instr_sequencer: RTL

Program sequencer that fetches 25-bit command words from a synchronous instruction memory and feeds them, one at a time, into the datapath control FSM's `command` input. It waits for the FSM's `done` before advancing, inserts a bubble command between instructions so that repeated opcodes are re-triggered, and applies jumps signalled by `jmpen`. It sits between instruction memory and the datapath FSM and is the only driver of `command`.

---
 rtl/seq_pkg.sv | 28 ++
 rtl/instr_sequencer_if.sv | 26 ++
 rtl/seq_watchdog.sv | 28 ++
 rtl/instr_sequencer.sv | 118 +++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the instruction sequencer.
// Command word layout: {func[4:0], rx[3:0], data[15:0]}.
package seq_pkg;

    localparam int CMD_W   = 25;
    localparam int FUNC_HI = 24;
    localparam int FUNC_LO = 20;

    localparam logic [4:0] OP_HALT   = 5'b11100;
    localparam logic [4:0] OP_BUBBLE = 5'b11111;

    localparam logic [CMD_W-1:0] BUBBLE_CMD = {OP_BUBBLE, 20'b0};

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_ISSUE,
        S_BUBBLE,
        S_HALT,
        S_ERROR
    } state_t;

    function automatic logic [4:0] func_of(input logic [CMD_W-1:0] w);
        return w[FUNC_HI:FUNC_LO];
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Instruction-memory read port and datapath command/handshake bundle.
// master = sequencer side, slave = memory + datapath side.
interface instr_sequencer_if #(
    parameter int AW = 8
);
    import seq_pkg::*;

    logic             imem_rd;
    logic [AW-1:0]    imem_addr;
    logic [CMD_W-1:0] imem_data;
    logic [CMD_W-1:0] command;
    logic             done;
    logic             jmpen;
    logic [AW-1:0]    jmp_target;

    modport master (
        output imem_rd, imem_addr, command,
        input  imem_data, done, jmpen, jmp_target
    );

    modport slave (
        input  imem_rd, imem_addr, command,
        output imem_data, done, jmpen, jmp_target
    );

endinterface

// File: rtl/seq_watchdog.sv
// Loadable down-counter; expired is high while the count sits at zero.
// Shared by the ISSUE timeout and the BUBBLE hold.
module seq_watchdog #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic [W-1:0] load,
    input  logic         enable,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= load;
        end else if (enable && cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/instr_sequencer.sv
// Program sequencer: fetch, issue to the datapath FSM, wait for done,
// insert a bubble so repeated opcodes re-trigger, and follow jumps.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int AW            = 8,
    parameter int TIMEOUT       = 64,
    parameter int BUBBLE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    instr_sequencer_if.master     bus,
    output logic [AW-1:0]         pc,
    output logic                  busy,
    output logic                  halted,
    output logic                  error,
    output logic [15:0]           retired
);

    localparam int WD_MAX = (TIMEOUT > BUBBLE_CYCLES) ? TIMEOUT : BUBBLE_CYCLES;
    localparam int WD_W   = $clog2(WD_MAX + 1);

    localparam logic [WD_W-1:0] TO_LOAD = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0] BB_LOAD = WD_W'(BUBBLE_CYCLES - 1);

    state_t          state;
    logic            wd_clear;
    logic            wd_enable;
    logic            wd_expired;
    logic [WD_W-1:0] wd_load;

    // Counter is loaded one cycle ahead, so it hits zero on the last
    // cycle of the ISSUE window or of the BUBBLE hold.
    assign wd_clear  = (state == S_LATCH) || (state == S_ISSUE && bus.done);
    assign wd_load   = (state == S_LATCH) ? TO_LOAD : BB_LOAD;
    assign wd_enable = (state == S_ISSUE) || (state == S_BUBBLE);

    seq_watchdog #(
        .W(WD_W)
    ) u_wd (
        .clk     (clk),
        .reset   (reset),
        .clear   (wd_clear),
        .load    (wd_load),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            pc            <= '0;
            bus.imem_rd   <= 1'b0;
            bus.imem_addr <= '0;
            bus.command   <= BUBBLE_CMD;
            busy          <= 1'b0;
            halted        <= 1'b0;
            error         <= 1'b0;
            retired       <= '0;
        end else begin
            unique case (state)
                S_IDLE, S_HALT, S_ERROR: begin
                    if (start) begin
                        state         <= S_FETCH;
                        pc            <= '0;
                        bus.imem_rd   <= 1'b1;
                        bus.imem_addr <= '0;
                        busy          <= 1'b1;
                        halted        <= 1'b0;
                        error         <= 1'b0;
                        retired       <= '0;
                    end
                end
                S_FETCH: begin
                    state       <= S_LATCH;
                    bus.imem_rd <= 1'b0;
                end
                S_LATCH: begin
                    if (func_of(bus.imem_data) == OP_HALT) begin
                        state  <= S_HALT;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                    end else begin
                        state       <= S_ISSUE;
                        bus.command <= bus.imem_data;
                    end
                end
                S_ISSUE: begin
                    if (bus.done) begin
                        state       <= S_BUBBLE;
                        bus.command <= BUBBLE_CMD;
                        pc          <= bus.jmpen ? bus.jmp_target : pc + AW'(1);
                        if (retired != 16'hFFFF) begin
                            retired <= retired + 16'd1;
                        end
                    end else if (wd_expired) begin
                        state       <= S_ERROR;
                        bus.command <= BUBBLE_CMD;
                        busy        <= 1'b0;
                        error       <= 1'b1;
                    end
                end
                S_BUBBLE: begin
                    if (wd_expired) begin
                        state         <= S_FETCH;
                        bus.imem_rd   <= 1'b1;
                        bus.imem_addr <= pc;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
